// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sequencing two requesters onto one async RAM port
module ram_port_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic                  write_0,
    input  logic                  write_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  ack_0,
    output logic                  ack_1,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_chip_select,
    output logic                  ram_write_enable,
    output logic                  ram_out_enable
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  wr_q, wr_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
    logic                  ack0_q, ack1_q, busy_q, cs_q, we_q, oe_q;

    // Next-state: grant in IDLE (round robin on ties), count ACCESS cycles, then DONE
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req_0 || req_1) begin
                sel_d   = (req_0 && req_1) ? ~last_q : req_1;
                wr_d    = sel_d ? write_1 : write_0;
                addr_d  = sel_d ? addr_1 : addr_0;
                wdata_d = sel_d ? wdata_1 : wdata_0;
                last_d  = sel_d;
                state_d = SETUP;
            end
            SETUP: begin
                cnt_d   = CW'(WAIT_CYCLES - 1);
                state_d = ACCESS;
            end
            ACCESS: if (cnt_q == '0) state_d = DONE; else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // State and all outputs registered from the next state so RAM controls never glitch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            if (state_q == ACCESS && cnt_q == '0 && !wr_q && !sel_q) rdata0_q <= ram_data;
            if (state_q == ACCESS && cnt_q == '0 && !wr_q && sel_q) rdata1_q <= ram_data;
            ack0_q   <= state_d == DONE && !sel_d;
            ack1_q   <= state_d == DONE && sel_d;
            busy_q   <= state_d != IDLE;
            cs_q     <= state_d == SETUP || state_d == ACCESS;
            we_q     <= state_d == ACCESS && wr_d;
            oe_q     <= state_d == ACCESS && !wr_d;
        end
    end

    assign ram_data         = we_q ? wdata_q : 'z;
    assign ram_address      = addr_q;
    assign ram_chip_select  = cs_q;
    assign ram_write_enable = we_q;
    assign ram_out_enable   = oe_q;
    assign ack_0            = ack0_q;
    assign ack_1            = ack1_q;
    assign rdata_0          = rdata0_q;
    assign rdata_1          = rdata1_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench for ram_port_arbiter (W=1 and W=3 instances)
module tb_ram_port_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       req_0, req_1, write_0, write_1;
    logic [7:0] addr_0, addr_1, wdata_0, wdata_1;
    logic       ack_0, ack_1, busy, cs, we, oe;
    logic [7:0] rdata_0, rdata_1, ram_address;
    wire  [7:0] ram_data;
    logic [7:0] mem [256];

    logic       req3;
    logic [7:0] addr3;
    logic       ack3, ack3b, busy3, cs3, we3, oe3;
    logic [7:0] rdata3, rdata3b, ad3;
    wire  [7:0] data3;
    logic [7:0] mem3 [256];

    ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .req_1(req_1), .write_0(write_0), .write_1(write_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .ack_0(ack_0), .ack_1(ack_1), .rdata_0(rdata_0), .rdata_1(rdata_1), .busy(busy),
        .ram_address(ram_address), .ram_data(ram_data), .ram_chip_select(cs),
        .ram_write_enable(we), .ram_out_enable(oe)
    );

    ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .req_0(req3), .req_1(1'b0), .write_0(1'b0), .write_1(1'b0),
        .addr_0(addr3), .addr_1(8'h00), .wdata_0(8'h00), .wdata_1(8'h00),
        .ack_0(ack3), .ack_1(ack3b), .rdata_0(rdata3), .rdata_1(rdata3b), .busy(busy3),
        .ram_address(ad3), .ram_data(data3), .ram_chip_select(cs3),
        .ram_write_enable(we3), .ram_out_enable(oe3)
    );

    assign ram_data = (cs && oe) ? mem[ram_address] : 'z;
    assign data3    = (cs3 && oe3) ? mem3[ad3] : 'z;

    always @(posedge clock) if (cs && we) mem[ram_address] <= ram_data;
    always @(posedge clock) if (cs3 && we3) mem3[ad3] <= data3;

    typedef struct {
        logic       who;
        logic       rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q1[$], q3[$];
    exp_t e1, e3;
    int   vectors = 0, miscompares = 0, cyc = 0;
    logic hold0 = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push1(input logic who, input logic rd, input logic [7:0] d, input int c);
        q1.push_back('{who, rd, d, c});
    endtask

    task automatic go(input logic who, input logic wr, input logic [7:0] a, input logic [7:0] d);
        if (who) begin
            req_1 = 1'b1; write_1 = wr; addr_1 = a; wdata_1 = d;
        end else begin
            req_0 = 1'b1; write_0 = wr; addr_0 = a; wdata_0 = d;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            if (ack_0 && !hold0) req_0 = 1'b0;
            if (ack_1) req_1 = 1'b0;
        end
    endtask

    always @(negedge clock) if (!reset) begin
        chk("invariants", {we && oe, ack_0 && ack_1, we3 && oe3}, 0);
        if (ack_0 || ack_1) begin
            if (q1.size() == 0) chk("unexpected_ack", {ack_0, ack_1}, 0);
            else begin
                e1 = q1.pop_front();
                chk("ack_who", ack_1, e1.who);
                chk("ack_cycle", cyc, e1.cyc);
                if (e1.rd) chk("rdata", e1.who ? rdata_1 : rdata_0, e1.data);
            end
        end
        if (ack3) begin
            if (q3.size() == 0) chk("unexpected_ack3", ack3, 0);
            else begin
                e3 = q3.pop_front();
                chk("ack3_cycle", cyc, e3.cyc);
                chk("rdata3", rdata3, e3.data);
            end
        end
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1;
        {req_0, req_1, write_0, write_1} = '0;
        {addr_0, addr_1, wdata_0, wdata_1} = '0;
        req3 = 1'b0; addr3 = '0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_ctrl", {ack_0, ack_1, busy, cs, we, oe}, 0);
        chk("reset_addr", ram_address, 0);
        chk("reset_rdata", {rdata_0, rdata_1}, 0);
        reset = 1'b0;
        @(negedge clock);
        // single write
        go(0, 1'b1, 8'h05, 8'hA5);
        push1(0, 0, 8'h00, cyc + 3);
        step(1);
        chk("t1_setup", {cs, we, oe}, 3'b100);
        chk("t1_addr", ram_address, 8'h05);
        step(1);
        chk("t1_access", {cs, we, oe}, 3'b110);
        chk("t1_bus", ram_data, 8'hA5);
        step(1);
        chk("t1_done", {cs, we, oe, busy}, 4'b0001);
        chk("t1_mem", mem[5], 8'hA5);
        step(1);
        // read back by requester 1
        go(1, 1'b0, 8'h05, 8'h00);
        push1(1, 1, 8'hA5, cyc + 3);
        step(1);
        chk("t2_setup", {cs, we, oe}, 3'b100);
        step(1);
        chk("t2_access", {cs, we, oe}, 3'b101);
        step(2);
        // tie: last grant was 1, so 0 wins
        go(0, 1'b1, 8'h10, 8'h11);
        go(1, 1'b1, 8'h20, 8'h22);
        push1(0, 0, 8'h00, cyc + 3);
        push1(1, 0, 8'h00, cyc + 7);
        step(8);
        chk("t3_mem10", mem[8'h10], 8'h11);
        chk("t3_mem20", mem[8'h20], 8'h22);
        // lone req_0 then a tie: 1 wins
        go(0, 1'b0, 8'h10, 8'h00);
        push1(0, 1, 8'h11, cyc + 3);
        step(4);
        go(0, 1'b0, 8'h20, 8'h00);
        go(1, 1'b0, 8'h10, 8'h00);
        push1(1, 1, 8'h11, cyc + 3);
        push1(0, 1, 8'h22, cyc + 7);
        step(8);
        // fairness: req_0 held, req_1 raised mid-transaction twice
        hold0 = 1'b1;
        go(0, 1'b0, 8'h10, 8'h00);
        c = cyc;
        push1(0, 1, 8'h11, c + 3);
        push1(1, 1, 8'h22, c + 7);
        push1(0, 1, 8'h11, c + 11);
        push1(1, 1, 8'h22, c + 15);
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if (i == 1 || i == 9) go(1, 1'b0, 8'h20, 8'h00);
            if (i == 11) begin
                hold0 = 1'b0;
                req_0 = 1'b0;
            end
        end
        // reset during the ACCESS cycle of a write
        go(0, 1'b1, 8'h30, 8'h33);
        step(2);
        chk("t5_access", {cs, we, oe}, 3'b110);
        reset = 1'b1;
        #1;
        chk("t5_reset", {cs, we, oe, busy, ack_0, ack_1}, 0);
        req_0 = 1'b0;
        step(1);
        reset = 1'b0;
        step(3);
        chk("t5_idle", busy, 0);
        // tie right after reset: 0 wins
        go(0, 1'b0, 8'h10, 8'h00);
        go(1, 1'b0, 8'h20, 8'h00);
        push1(0, 1, 8'h11, cyc + 3);
        push1(1, 1, 8'h22, cyc + 7);
        step(8);
        // WAIT_CYCLES=3 read; data changes each ACCESS cycle, last value is sampled
        mem3[8'h40] = 8'h99;
        req3 = 1'b1;
        addr3 = 8'h40;
        q3.push_back('{1'b0, 1'b1, 8'h5C, cyc + 5});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            chk("t6_oe", oe3, (i >= 2 && i <= 4) ? 1 : 0);
            if (i == 2) mem3[8'h40] = 8'h11;
            if (i == 3) mem3[8'h40] = 8'h22;
            if (i == 4) mem3[8'h40] = 8'h5C;
            if (ack3) req3 = 1'b0;
        end
        step(3);
        chk("sb_empty", q1.size(), 0);
        chk("sb3_empty", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
